// File: rtl/mem_loader.sv
// mem_loader: streams bytes from a valid/ready source into word-wide memory
// (load mode) or compares memory contents against the stream (verify mode).
// Bytes are packed little-endian into a word buffer, then written (or read
// and compared) one word at a time. All outputs are registered.
module mem_loader #(
    parameter int  MEM_SIZE_BYTES   = 4096,
    parameter int  DATA_WIDTH_BYTES = 4,
    localparam int ADDR_WIDTH       = $clog2(MEM_SIZE_BYTES)
) (
    input  logic                          clk,
    input  logic                          rst_bar,
    input  logic                          start,
    input  logic                          mode,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH:0]           length,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH_BYTES-1:0]   mem_w_bar,
    output logic [8*DATA_WIDTH_BYTES-1:0] mem_data_w,
    input  logic [8*DATA_WIDTH_BYTES-1:0] mem_data_r,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [ADDR_WIDTH-1:0]         err_addr
);

    localparam int D  = DATA_WIDTH_BYTES;
    localparam int AW = ADDR_WIDTH;
    localparam int LW = (D > 1) ? $clog2(D) : 1;   // lane index width
    localparam int CW = $clog2(D) + 1;              // fill count holds 0..D

    localparam logic [AW-1:0] ALIGN_MASK = AW'(D - 1);
    localparam logic [AW+1:0] MEM_LIMIT  = (AW+2)'(MEM_SIZE_BYTES);

    typedef enum logic [2:0] {IDLE, FILL, WRITE, READ, CMP, DONE} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [AW-1:0]       addr_q, addr_d;      // current word address
    logic [AW:0]         rem_q, rem_d;        // bytes still to accept
    logic [CW-1:0]       cnt_q, cnt_d;        // lanes filled in current word
    logic [D-1:0][7:0]   wbuf_q, wbuf_d;

    logic                in_ready_q, in_ready_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [D-1:0]        mem_w_bar_q, mem_w_bar_d;
    logic [D-1:0][7:0]   mem_data_w_q, mem_data_w_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [AW-1:0]       err_addr_q, err_addr_d;

    logic [AW+1:0]       end_sum;
    logic                bad_job;
    logic [D-1:0]        fmask;
    logic                mis;
    logic [LW-1:0]       mis_lane;

    // Lanes below the fill count hold valid bytes.
    function automatic logic [D-1:0] lane_mask(input logic [CW-1:0] c);
        logic [D-1:0] m;
        for (int k = 0; k < D; k++) m[k] = (CW'(k) < c);
        return m;
    endfunction

    // Job sanity: word-aligned base and the whole range inside memory (no wrap).
    always_comb begin
        end_sum = {2'b00, base_addr} + {1'b0, length};
        bad_job = ((base_addr & ALIGN_MASK) != '0) || (end_sum > MEM_LIMIT);
    end

    // Find the lowest filled lane whose read data differs from the buffer.
    always_comb begin
        mis      = 1'b0;
        mis_lane = '0;
        fmask    = lane_mask(cnt_q);
        for (int k = D - 1; k >= 0; k--) begin
            if (fmask[k] && (mem_data_r[8*k +: 8] != wbuf_q[k])) begin
                mis      = 1'b1;
                mis_lane = LW'(k);
            end
        end
    end

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        wbuf_d       = wbuf_q;
        error_d      = error_q;
        err_addr_d   = err_addr_q;
        mem_addr_d   = mem_addr_q;
        mem_w_bar_d  = '1;
        mem_data_w_d = mem_data_w_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d     = mode;
                    addr_d     = base_addr;
                    rem_d      = length;
                    cnt_d      = '0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                    if (bad_job) begin
                        state_d    = DONE;
                        error_d    = 1'b1;
                        err_addr_d = base_addr;
                    end else if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (in_valid && in_ready_q) begin
                    wbuf_d[cnt_q[LW-1:0]] = in_data;
                    cnt_d = cnt_q + CW'(1);
                    rem_d = rem_q - (AW+1)'(1);
                    if ((cnt_d == CW'(D)) || (rem_d == '0))
                        state_d = mode_q ? READ : WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + AW'(D);
                cnt_d   = '0;
                state_d = (rem_q == '0) ? DONE : FILL;
            end
            READ: begin
                state_d = CMP;
            end
            CMP: begin
                if (mis) begin
                    state_d    = DONE;
                    error_d    = 1'b1;
                    err_addr_d = addr_q + AW'(mis_lane);
                end else begin
                    addr_d  = addr_q + AW'(D);
                    cnt_d   = '0;
                    state_d = (rem_q == '0) ? DONE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == WRITE) begin
            mem_addr_d   = addr_q;
            mem_w_bar_d  = ~lane_mask(cnt_d);
            mem_data_w_d = wbuf_d;
        end
        if (state_d == READ) mem_addr_d = addr_q;

        in_ready_d = (state_d == FILL);
        busy_d     = (state_d == FILL) || (state_d == WRITE) ||
                     (state_d == READ) || (state_d == CMP);
        done_d     = (state_d == DONE);
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            addr_q       <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            wbuf_q       <= '0;
            in_ready_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_w_bar_q  <= '1;
            mem_data_w_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            wbuf_q       <= wbuf_d;
            in_ready_q   <= in_ready_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_bar_q  <= mem_w_bar_d;
            mem_data_w_q <= mem_data_w_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_bar  = mem_w_bar_q;
    assign mem_data_w = mem_data_w_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: job table driven through a byte feeder, expected
// memory writes queued at job start and checked by a write monitor, backed
// by a byte-array memory model that answers reads one cycle late.
module tb_mem_loader;

    localparam int MEM = 4096;
    localparam int DWB = 4;
    localparam int AW  = 12;

    logic              clk = 1'b0;
    logic              rst_bar = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       length = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready;
    logic [AW-1:0]     mem_addr;
    logic [DWB-1:0]    mem_w_bar;
    logic [8*DWB-1:0]  mem_data_w;
    logic [8*DWB-1:0]  mem_data_r;
    logic              busy, done, error;
    logic [AW-1:0]     err_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_loader #(.MEM_SIZE_BYTES(MEM), .DATA_WIDTH_BYTES(DWB)) dut (
        .clk(clk), .rst_bar(rst_bar), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_addr(mem_addr),
        .mem_w_bar(mem_w_bar), .mem_data_w(mem_data_w), .mem_data_r(mem_data_r),
        .busy(busy), .done(done), .error(error), .err_addr(err_addr)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    wbar;
    } wr_t;

    typedef struct {
        logic          md;
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic [7:0]    first;
        int            corrupt;   // byte index replaced by 0xFF, -1 for none
        logic          tog;       // in_valid every other cycle
        logic          eerr;
        logic [AW-1:0] eaddr;
        int            ecyc;      // edges from start sample to done, 0 = unchecked
    } job_t;

    wr_t  exp_q[$];
    job_t jobs[12];
    logic [7:0] mem [0:MEM-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: byte-lane writes, registered read data.
    always @(posedge clk) begin
        for (int k = 0; k < DWB; k++) begin
            if (mem_w_bar[k] == 1'b0) mem[int'(mem_addr) + k] <= mem_data_w[8*k +: 8];
            mem_data_r[8*k +: 8] <= mem[int'(mem_addr) + k];
        end
    end

    // Write monitor: every write must match the next queued expectation.
    always @(negedge clk) begin
        wr_t         e;
        logic [31:0] m;
        if (rst_bar && (mem_w_bar !== 4'hF)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0h w_bar %b, expected no write", mem_addr, mem_w_bar);
            end else begin
                e = exp_q.pop_front();
                for (int k = 0; k < DWB; k++) m[8*k +: 8] = e.wbar[k] ? 8'h00 : 8'hFF;
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_wbar", 32'(mem_w_bar), 32'(e.wbar));
                chk("wr_data", mem_data_w & m, e.data & m);
                chk("in_ready_in_write", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic run_job(input job_t j, input string tag);
        logic [7:0] bytes [0:31];
        int   n, i, cyc, nl;
        logic xfer, ph;
        wr_t  e;
        n = int'(j.len);
        for (int b = 0; b < n; b++) bytes[b] = j.first + 8'(b);
        if (j.corrupt >= 0) bytes[j.corrupt] = 8'hFF;
        if (!j.md && !j.eerr) begin
            for (int w = 0; w < n; w += DWB) begin
                nl     = (n - w < DWB) ? n - w : DWB;
                e.addr = j.base + AW'(w);
                e.data = '0;
                e.wbar = 4'hF;
                for (int k = 0; k < nl; k++) begin
                    e.data[8*k +: 8] = bytes[w + k];
                    e.wbar[k] = 1'b0;
                end
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b1; mode = j.md; base_addr = j.base; length = j.len;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; i = 0; ph = 1'b1;
        while (!done && cyc < 300) begin
            in_valid = (i < n) && (!j.tog || ph);
            in_data  = (i < n) ? bytes[i] : 8'h00;
            xfer     = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (xfer) i++;
            ph = ~ph;
        end
        in_valid = 1'b0;
        if (cyc >= 300) $display("FAIL %s_timeout: done not seen after %0d cycles", tag, cyc);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'(j.eerr));
        chk({tag, "_err_addr"}, 32'(err_addr), 32'(j.eaddr));
        if (j.ecyc > 0) chk({tag, "_cycles"}, 32'(cyc), 32'(j.ecyc));
        if (!j.eerr) chk({tag, "_consumed"}, 32'(i), 32'(n));
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_err_addr"}, 32'(err_addr), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_w_bar"}, 32'(mem_w_bar), 32'hF);
        chk({tag, "_data_w"}, mem_data_w, 32'd0);
    endtask

    initial begin
        job_t rj;
        for (int a = 0; a < MEM; a++) mem[a] = 8'h00;
        //          md    base     len     first  corr tog  eerr eaddr    ecyc
        jobs[0]  = '{1'b0, 12'h010, 13'd8, 8'h01, -1, 1'b0, 1'b0, 12'h000, 11};
        jobs[1]  = '{1'b0, 12'h000, 13'd6, 8'hAA, -1, 1'b0, 1'b0, 12'h000, 9};
        jobs[2]  = '{1'b1, 12'h010, 13'd8, 8'h01,  5, 1'b0, 1'b1, 12'h015, 13};
        jobs[3]  = '{1'b1, 12'h000, 13'd6, 8'hAA, -1, 1'b0, 1'b0, 12'h000, 11};
        jobs[4]  = '{1'b0, 12'h002, 13'd8, 8'h00, -1, 1'b0, 1'b1, 12'h002, 1};
        jobs[5]  = '{1'b0, 12'hFFC, 13'd8, 8'h00, -1, 1'b0, 1'b1, 12'hFFC, 1};
        jobs[6]  = '{1'b1, 12'h002, 13'd8, 8'h00, -1, 1'b0, 1'b1, 12'h002, 1};
        jobs[7]  = '{1'b0, 12'h020, 13'd0, 8'h00, -1, 1'b0, 1'b0, 12'h000, 1};
        jobs[8]  = '{1'b0, 12'h040, 13'd4, 8'h30, -1, 1'b1, 1'b0, 12'h000, 0};
        jobs[9]  = '{1'b0, 12'hFFC, 13'd4, 8'hC0, -1, 1'b0, 1'b0, 12'h000, 6};
        jobs[10] = '{1'b1, 12'hFFC, 13'd4, 8'hC0,  0, 1'b0, 1'b1, 12'hFFC, 7};
        jobs[11] = '{1'b0, 12'h080, 13'd5, 8'h50, -1, 1'b0, 1'b0, 12'h000, 8};

        #2 rst_bar = 1'b0;
        #10 chk_reset_outputs("por");
        @(negedge clk) rst_bar = 1'b1;

        for (int j = 0; j < 12; j++) run_job(jobs[j], $sformatf("job%0d", j));

        // Reset in the middle of a fill: nothing may be written, outputs clear at once.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = 12'h100; length = 13'd8;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        @(posedge clk); #1;
        in_data = 8'h22;
        @(posedge clk); #1;
        chk("midfill_busy", 32'(busy), 32'd1);
        rst_bar = 1'b0;
        #1 chk_reset_outputs("rst_async");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("rst_held");
        @(negedge clk) rst_bar = 1'b1;

        rj = '{1'b0, 12'h100, 13'd8, 8'h90, -1, 1'b0, 1'b0, 12'h000, 11};
        run_job(rj, "post_rst_load");
        rj = '{1'b1, 12'h100, 13'd8, 8'h90, -1, 1'b0, 1'b0, 12'h000, 13};
        run_job(rj, "post_rst_verify");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE_BYTES, default 4096: target memory size in bytes; power of 2.
REQ-002 SHALL have parameter DATA_WIDTH_BYTES, default 4: byte lanes per memory word; power of 2, 1..8.
REQ-003 SHALL derive localparam ADDR_WIDTH = $clog2(MEM_SIZE_BYTES).
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; all state updates on posedge.
- rst_bar  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled in IDLE/DONE only.
- mode  in  1  0 = load, 1 = verify; captured at start.
- base_addr  in  ADDR_WIDTH  job start byte address; captured at start.
- length  in  ADDR_WIDTH+1  job length in bytes; captured at start.
- in_valid  in  1  source byte valid.
- in_data  in  8  source byte.
- in_ready  out  1  loader accepts a byte; transfer when in_valid & in_ready.
- mem_addr  out  ADDR_WIDTH  word-aligned byte address to memory.
- mem_w_bar  out  DATA_WIDTH_BYTES  per-lane write enable, active-low.
- mem_data_w  out  8*DATA_WIDTH_BYTES  write data; lane k = bits [8k+7:8k].
- mem_data_r  in  8*DATA_WIDTH_BYTES  read data, valid one cycle after mem_addr is presented.
- busy  out  1  job in progress.
- done  out  1  job finished; held until next accepted start.
- error  out  1  job failed; held until next accepted start.
- err_addr  out  ADDR_WIDTH  byte address of failure.

Function
REQ-005 SHALL implement states IDLE, FILL, WRITE, READ, CMP, DONE; all outputs registered.
REQ-006 IDLE/DONE + start: capture mode/base_addr/length, clear done/error/err_addr, set busy, go to FILL; start ignored in all other states.
REQ-007 At start, SHALL go directly to DONE with error=1, err_addr=base_addr, no memory access, if base_addr not multiple of DATA_WIDTH_BYTES or base_addr+length > MEM_SIZE_BYTES (no wrap-around).
REQ-008 At start with length=0 and valid base_addr: DONE next cycle, error=0, no memory access.
REQ-009 FILL: in_ready=1; each transfer places byte in lane = fill count (little-endian), decrements remaining length.
REQ-010 FILL exits when lanes full or remaining reaches 0, on the cycle after the last transfer: mode 0 -> WRITE, mode 1 -> READ; in_ready=0 outside FILL.
REQ-011 WRITE (one cycle): mem_addr = current word address, mem_w_bar lane=0 only for filled lanes (partial final word leaves upper lanes 1), mem_data_w = buffer; then advance address by DATA_WIDTH_BYTES, clear fill count, go to FILL, or DONE if remaining=0.
REQ-012 READ (one cycle): mem_addr = current word address, mem_w_bar all 1; CMP next cycle.
REQ-013 CMP: compare mem_data_r with buffer on filled lanes only; on mismatch set error=1, err_addr = address of lowest mismatching byte, go to DONE; else advance as REQ-011.
REQ-014 mem_w_bar SHALL be all 1 in every state except WRITE.
REQ-015 DONE: busy=0, done=1; stays until accepted start.
REQ-016 in_valid high outside FILL SHALL have no effect; in_data only sampled on transfer.
REQ-017 Load throughput: DATA_WIDTH_BYTES+1 cycles per full word with continuous in_valid; verify: DATA_WIDTH_BYTES+2.

Reset
REQ-018 rst_bar low SHALL immediately force IDLE, busy=0, done=0, error=0, err_addr=0, in_ready=0, mem_addr=0, mem_w_bar all 1, mem_data_w=0, clearing any job in progress; no partial write completes.
REQ-019 After rst_bar release, first start is accepted on the first posedge it is sampled.

Verification (DATA_WIDTH_BYTES=4, MEM_SIZE_BYTES=4096)
REQ-020 Load base=0x010, length=8, bytes 01..08 -> writes 0x010 data 0x04030201 w_bar 0000, 0x014 data 0x08070605 w_bar 0000; done=1, error=0.
REQ-021 Load base=0x000, length=6, bytes AA..AF -> second write mem_addr=0x004, w_bar 1100, lanes 0-1 = AE,AF.
REQ-022 Verify same 8 bytes after REQ-020 with byte 6 changed to 0xFF -> error=1, err_addr=0x015, done=1, no writes.
REQ-023 Start base=0x002 or base=0xFFC length=8 -> next cycle done=1, error=1, err_addr=base, mem_w_bar never 0.
REQ-024 Load with in_valid toggling every other cycle, length=4 -> single write after 4th transfer, in_ready low during WRITE.
REQ-025 rst_bar low mid-FILL of a job, then new start -> all outputs at reset values during reset, new job completes correctly from its base.
